// File: rtl/sw_key_reader_if.sv
// Native PicoRV32-style memory bus between the SoC fabric and one responder.
// The SoC drives the request side (master); the peripheral answers (slave).
interface sw_key_reader_if;
    logic        mem_valid;
    logic        sel;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, sel, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, sel, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/sw_key_reader.sv
// Switch/button reader: synchronise, debounce, latch key presses, raise irq.
// Exposes SW_STATE, KEY_STATE, KEY_EDGE (W1C) and IRQ_EN on the memory bus.
module sw_key_reader #(
    parameter int NUM_SW          = 10,
    parameter int NUM_KEY         = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NUM_SW-1:0]  sw,
    input  logic [NUM_KEY-1:0] key_n,
    sw_key_reader_if.slave     bus,
    output logic               irq
);

    localparam int NB = NUM_SW + NUM_KEY;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        S_IDLE,
        S_RESP
    } state_t;

    logic [NB-1:0]                   w_raw;
    logic [SYNC_STAGES-1:0][NB-1:0]  r_sync;
    logic [NB-1:0]                   w_synced;
    logic [CW-1:0]                   r_cnt [NB];
    logic [NB-1:0]                   r_stable;
    logic [NB-1:0]                   w_flip;
    logic [NUM_SW-1:0]               w_sw_stab;
    logic [NUM_KEY-1:0]              w_key_stab;
    logic [NUM_KEY-1:0]              w_rise;
    logic [NUM_KEY-1:0]              r_key_edge;
    logic [NUM_KEY-1:0]              r_irq_en;
    logic                            r_irq;
    state_t                          r_state;
    state_t                          w_next;
    logic                            w_accept;
    logic                            w_read;
    logic                            w_write;
    logic [31:0]                     w_byte_mask;
    logic [NUM_KEY-1:0]              w_clr;
    logic [NUM_KEY-1:0]              w_en_mask;
    logic [31:0]                     w_rd;
    logic [31:0]                     r_rdata;
    logic                            w_unused;

    // Keys are inverted up front so every internal bit reads 1 = active.
    assign w_raw    = {~key_n, sw};
    assign w_synced = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw};
        end
    end

    always_comb begin
        w_flip = '0;
        for (int i = 0; i < NB; i++) begin
            w_flip[i] = (w_synced[i] != r_stable[i]) &&
                        (r_cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NB; i++) begin
                r_cnt[i] <= '0;
            end
            r_stable <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if ((w_synced[i] == r_stable[i]) || w_flip[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
            r_stable <= r_stable ^ w_flip;
        end
    end

    assign w_sw_stab  = r_stable[NUM_SW-1:0];
    assign w_key_stab = r_stable[NB-1:NUM_SW];
    assign w_rise     = w_flip[NB-1:NUM_SW] & w_synced[NB-1:NUM_SW];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    assign w_accept = (r_state == S_IDLE) && bus.mem_valid && bus.sel;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept) w_next = S_RESP;
            S_RESP: w_next = S_IDLE;
        endcase
    end

    assign w_read  = w_accept && (bus.mem_wstrb == 4'd0);
    assign w_write = w_accept && (bus.mem_wstrb != 4'd0);

    assign w_byte_mask = {{8{bus.mem_wstrb[3]}}, {8{bus.mem_wstrb[2]}},
                          {8{bus.mem_wstrb[1]}}, {8{bus.mem_wstrb[0]}}};

    assign w_clr = (w_write && bus.mem_addr[3:2] == 2'd2)
                 ? (bus.mem_wdata[NUM_KEY-1:0] & w_byte_mask[NUM_KEY-1:0])
                 : '0;

    assign w_en_mask = (w_write && bus.mem_addr[3:2] == 2'd3)
                     ? w_byte_mask[NUM_KEY-1:0]
                     : '0;

    // A press landing on the same edge as its W1C keeps the bit set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_key_edge <= '0;
            r_irq_en   <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_key_edge <= (r_key_edge & ~w_clr) | w_rise;
            r_irq_en   <= (r_irq_en & ~w_en_mask) |
                          (bus.mem_wdata[NUM_KEY-1:0] & w_en_mask);
            r_irq      <= |(r_key_edge & r_irq_en);
        end
    end

    always_comb begin
        w_rd = '0;
        unique case (bus.mem_addr[3:2])
            2'd0: w_rd = 32'(w_sw_stab);
            2'd1: w_rd = 32'(w_key_stab);
            2'd2: w_rd = 32'(r_key_edge);
            2'd3: w_rd = 32'(r_irq_en);
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= w_read ? w_rd : '0;
        end
    end

    assign bus.mem_ready = (r_state == S_RESP);
    assign bus.mem_rdata = r_rdata;
    assign irq           = r_irq;

    assign w_unused = ^{bus.mem_addr[1:0], bus.mem_wdata};

endmodule

// File: tb/tb_sw_key_reader.sv
// Bench for sw_key_reader: directed scenarios then random stimulus,
// every cycle compared against a window-based behavioural model.
module tb_sw_key_reader;

    localparam int NSW = 10;
    localparam int NK  = 4;
    localparam int D   = 4;
    localparam int S   = 2;
    localparam int NB  = NSW + NK;

    logic            clk    = 1'b0;
    logic            resetn = 1'b0;
    logic [NSW-1:0]  sw     = '0;
    logic [NK-1:0]   key_n  = '1;
    logic            irq;

    sw_key_reader_if bus ();

    sw_key_reader #(
        .NUM_SW          (NSW),
        .NUM_KEY         (NK),
        .DEBOUNCE_CYCLES (D),
        .SYNC_STAGES     (S)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .sw     (sw),
        .key_n  (key_n),
        .bus    (bus),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: raw history window, stable values, registers, bus response.
    logic [NB-1:0] hist [S+D];
    logic [NB-1:0] m_stab;
    logic [NK-1:0] m_edge;
    logic [NK-1:0] m_en;
    logic          m_irq;
    logic          m_resp;
    logic [31:0]   m_rdata;

    task automatic model_clear();
        for (int j = 0; j < S + D; j++) hist[j] = '0;
        m_stab  = '0;
        m_edge  = '0;
        m_en    = '0;
        m_irq   = 1'b0;
        m_resp  = 1'b0;
        m_rdata = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        logic [NB-1:0] raw;
        logic [NB-1:0] ns;
        logic [NK-1:0] rise;
        logic [NK-1:0] clr;
        logic [31:0]   rd;
        logic [31:0]   wd;
        logic [3:0]    ws;
        logic [3:0]    ad;
        logic          acc;
        logic          irq_n;
        logic          all_diff;
        raw = {~key_n, sw};
        acc = !m_resp && bus.mem_valid && bus.sel;
        ws  = bus.mem_wstrb;
        ad  = bus.mem_addr;
        wd  = bus.mem_wdata;
        @(posedge clk);
        #1;
        if (!resetn) begin
            model_clear();
        end else begin
            irq_n = |(m_edge & m_en);
            rd = '0;
            if (acc && ws == 4'd0) begin
                case (ad[3:2])
                    2'd0: rd = {22'd0, m_stab[NSW-1:0]};
                    2'd1: rd = {28'd0, m_stab[NB-1:NSW]};
                    2'd2: rd = {28'd0, m_edge};
                    default: rd = {28'd0, m_en};
                endcase
            end
            for (int k = S + D - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = raw;
            // A bit settles once the synchronised input has disagreed
            // with it for D consecutive edges.
            ns = m_stab;
            for (int b = 0; b < NB; b++) begin
                all_diff = 1'b1;
                for (int j = S; j < S + D; j++) begin
                    if (hist[j][b] == m_stab[b]) all_diff = 1'b0;
                end
                if (all_diff) ns[b] = ~m_stab[b];
            end
            rise = ns[NB-1:NSW] & ~m_stab[NB-1:NSW];
            clr  = (acc && ws[0] && ad[3:2] == 2'd2) ? wd[NK-1:0] : 4'd0;
            m_edge = (m_edge & ~clr) | rise;
            if (acc && ws[0] && ad[3:2] == 2'd3) m_en = wd[NK-1:0];
            m_stab  = ns;
            m_rdata = rd;
            m_resp  = acc;
            m_irq   = irq_n;
        end
        chk("ready", 32'(bus.mem_ready), 32'(m_resp));
        chk("rdata", bus.mem_rdata, m_rdata);
        chk("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic bus_op(input logic [3:0] a, input logic [31:0] d,
                          input logic [3:0] st, output logic [31:0] rd);
        bus.mem_valid = 1'b1;
        bus.sel       = 1'b1;
        bus.mem_addr  = a;
        bus.mem_wdata = d;
        bus.mem_wstrb = st;
        tick();
        rd = bus.mem_rdata;
        bus.mem_valid = 1'b0;
        bus.sel       = 1'b0;
        bus.mem_wstrb = 4'd0;
        tick();
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a,
                          input logic [31:0] want);
        logic [31:0] v;
        bus_op(a, 32'd0, 4'd0, v);
        chk(tag, v, want);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d,
                      input logic [3:0] st);
        logic [31:0] v;
        bus_op(a, d, st, v);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v;
        logic [5:0]  pat;
        logic        anyr;
        int          b;

        bus.mem_valid = 1'b0;
        bus.sel       = 1'b0;
        bus.mem_addr  = 4'd0;
        bus.mem_wdata = 32'd0;
        bus.mem_wstrb = 4'd0;
        model_clear();

        // Reset with every input active
        resetn = 1'b0;
        sw     = 10'h3FF;
        key_n  = 4'h0;
        repeat (3) tick();
        chk("rst_ready", 32'(bus.mem_ready), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        resetn = 1'b1;
        rd_chk("rst_sw", 4'h0, 32'd0);
        rd_chk("rst_key", 4'h4, 32'd0);
        rd_chk("rst_edge", 4'h8, 32'd0);
        rd_chk("rst_en", 4'hC, 32'd0);
        rd_chk("sw_state", 4'h0, 32'h3FF);
        rd_chk("key_state", 4'h4, 32'hF);
        rd_chk("key_edge_all", 4'h8, 32'hF);
        wr(4'h8, 32'hF, 4'h1);
        rd_chk("edge_clr", 4'h8, 32'd0);
        key_n = 4'hF;
        repeat (8) tick();
        rd_chk("key_rel", 4'h4, 32'd0);

        // Glitch shorter than the debounce window
        key_n = 4'hE;
        repeat (3) tick();
        key_n = 4'hF;
        repeat (8) tick();
        rd_chk("glitch_key", 4'h4, 32'd0);
        rd_chk("glitch_edge", 4'h8, 32'd0);

        // Clean press: stable at edge 6, irq one edge later
        wr(4'hC, 32'h1, 4'h1);
        key_n = 4'hE;
        repeat (6) tick();
        chk("irq_lat6", 32'(irq), 32'd0);
        tick();
        chk("irq_lat7", 32'(irq), 32'd1);
        repeat (3) tick();
        rd_chk("press_key", 4'h4, 32'h1);
        rd_chk("press_edge", 4'h8, 32'h1);

        // W1C and strobe gating
        wr(4'h8, 32'h1, 4'h1);
        chk("w1c_irq", 32'(irq), 32'd0);
        rd_chk("w1c_edge", 4'h8, 32'd0);
        key_n = 4'hF;
        repeat (8) tick();
        key_n = 4'hE;
        repeat (8) tick();
        chk("irq_again", 32'(irq), 32'd1);
        wr(4'h8, 32'h0, 4'h1);
        rd_chk("w0_edge", 4'h8, 32'h1);
        wr(4'h8, 32'h1, 4'h2);
        rd_chk("strb_edge", 4'h8, 32'h1);
        chk("strb_irq", 32'(irq), 32'd1);
        wr(4'h8, 32'h1, 4'h1);
        rd_chk("edge_clr2", 4'h8, 32'd0);
        wr(4'h0, 32'hFFFF_FFFF, 4'hF);
        rd_chk("ro_sw", 4'h0, 32'h3FF);

        // W1C of bit 2 on the very edge its press is recognised
        key_n = 4'hA;
        repeat (5) tick();
        wr(4'h8, 32'h4, 4'h1);
        rd_chk("race_edge", 4'h8, 32'h4);
        key_n = 4'hF;
        repeat (8) tick();
        wr(4'h8, 32'hF, 4'h1);

        // Back-to-back requests and deselected requests
        pat = '0;
        bus.mem_valid = 1'b1;
        bus.sel       = 1'b1;
        bus.mem_addr  = 4'h0;
        bus.mem_wstrb = 4'h0;
        for (int i = 0; i < 6; i++) begin
            pat = {pat[4:0], bus.mem_ready};
            tick();
        end
        chk("hs_pat", 32'(pat), 32'b010101);
        bus.sel = 1'b0;
        anyr    = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            anyr = anyr | bus.mem_ready;
        end
        chk("nosel", 32'(anyr), 32'd0);
        bus.mem_valid = 1'b0;

        // Reset while responding and mid-debounce
        key_n = 4'hD;
        repeat (3) tick();
        bus.mem_valid = 1'b1;
        bus.sel       = 1'b1;
        bus.mem_addr  = 4'h4;
        tick();
        chk("mid_ready", 32'(bus.mem_ready), 32'd1);
        bus.mem_valid = 1'b0;
        bus.sel       = 1'b0;
        key_n  = 4'hF;
        resetn = 1'b0;
        #1;
        chk("arst_ready", 32'(bus.mem_ready), 32'd0);
        chk("arst_rdata", bus.mem_rdata, 32'd0);
        model_clear();
        repeat (2) tick();
        resetn = 1'b1;
        repeat (10) tick();
        rd_chk("stale_key", 4'h4, 32'd0);
        rd_chk("stale_edge", 4'h8, 32'd0);

        // Random inputs and bus traffic
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(7) == 0) begin
                b = int'($urandom_range(NSW - 1));
                sw[b] = ~sw[b];
            end
            if ($urandom_range(5) == 0) begin
                b = int'($urandom_range(NK - 1));
                key_n[b] = ~key_n[b];
            end
            if ($urandom_range(2) == 0) begin
                bus_op(4'($urandom), $urandom,
                       ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom), v);
            end else begin
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
